// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
// The datapath width is pinned to 8 by the CarryAdder it is built around.
package mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int MULT_ITER  = 8;
    localparam int CNT_W      = $clog2(MULT_ITER);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier8_adder.sv
// The existing 8-bit ripple-carry adder.
// The multiplier reuses it unchanged for every partial-product add.
module CarryAdder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [8:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[8];

endmodule

// File: rtl/shift_add_multiplier8.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per clock through CarryAdder.
// Accepts a start in IDLE, iterates 8 times in CALC, and pulses done for one cycle in DONE.
module shift_add_multiplier8
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITER  = MULT_ITER
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    mult_state_t          state_q, state_d;
    logic [WIDTH-1:0]     m_q,     m_d;
    logic [WIDTH-1:0]     acc_q,   acc_d;
    logic [WIDTH-1:0]     q_q,     q_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]   p_q,     p_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 sumCout;

    // The carry-out of each add drops straight into ACC[7] on the shift,
    // so the separate carry bit is always zero afterwards and is not kept.
    assign addend = q_q[0] ? m_q : '0;

    CarryAdder u_adder (
        .A    (acc_q),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (sumCout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {sumCout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // Last iteration: the product is the freshly shifted {ACC, Q}.
                if (cnt_q == LAST_CNT) begin
                    p_d     = {sumCout, sum, q_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier8.sv
// Scoreboard bench for shift_add_multiplier8: stimulus pushes expected products,
// a negedge monitor pops and compares whenever done is seen.
module tb_shift_add_multiplier8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        busy;
    logic        done;
    logic [15:0] P;

    int          errors = 0;
    int          checks = 0;
    int          busyRun = 0;
    logic [15:0] expQ[$];

    shift_add_multiplier8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every done and checks busy-window length.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busyRun = 0;
            end else begin
                if (busy) busyRun++;
                if (done) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpectedDone: got done with P=%h, required no done", P);
                    end else begin
                        logic [15:0] e;
                        e = expQ.pop_front();
                        if (P !== e || busy !== 1'b0) begin
                            errors++;
                            $display("[TB] FAIL product: got P=%h busy=%b, required P=%h busy=0", P, busy, e);
                        end
                    end
                    checks++;
                    if (busyRun != 8) begin
                        errors++;
                        $display("[TB] FAIL busyCycles: got %0d, required 8", busyRun);
                    end
                    busyRun = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic expBusy, input logic expDone,
                               input logic [15:0] expP);
        checks++;
        if (busy !== expBusy || done !== expDone || P !== expP) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%b done=%b P=%h, required busy=%b done=%b P=%h",
                     name, busy, done, P, expBusy, expDone, expP);
        end
    endtask

    task automatic waitIdle(input string name);
        int guard = 0;
        while ((busy || done) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got busy=%b done=%b after 50 cycles, required idle", name, busy, done);
        end
    endtask

    // Issues one request from IDLE; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expP, input bit push);
        @(negedge clk);
        waitIdle("waitIdleBeforeStart");
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) expQ.push_back(expP);
        @(negedge clk);
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
    endtask

    initial begin
        int edges;

        // Reset with random inputs toggling
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A     = 8'($urandom);
            B     = 8'($urandom);
            start = 1'($urandom);
            @(negedge clk);
            checkOutput("resetHeld", 1'b0, 1'b0, 16'h0000);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idleAfterReset", 1'b0, 1'b0, 16'h0000);

        // Basic product with latency measurement (accept edge counts as edge 1)
        applyStimulus(8'h0F, 8'h01, 16'h000F, 1'b1);
        edges = 1;
        while (!done && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != 9) begin
            errors++;
            $display("[TB] FAIL latency: got %0d edges, required 9", edges);
        end

        // Directed products
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        applyStimulus(8'hAA, 8'h55, 16'h3872, 1'b1);
        applyStimulus(8'hD7, 8'h95, 16'h7D23, 1'b1);
        applyStimulus(8'h00, 8'hFF, 16'h0000, 1'b1);
        applyStimulus(8'h09, 8'h32, 16'h01C2, 1'b1);

        // Start during CALC is ignored
        applyStimulus(8'h03, 8'h04, 16'h000C, 1'b1);
        repeat (2) @(negedge clk);
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle("ignoredStartDrain");
        repeat (12) @(negedge clk);
        checkOutput("holdAfterIgnored", 1'b0, 1'b0, 16'h000C);

        // Abort mid-operation
        applyStimulus(8'hFF, 8'hFF, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("busyBeforeAbort", 1'b1, 1'b0, 16'h000C);
        rst_n = 1'b0;
        #1;
        checkOutput("abortImmediate", 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("noDoneAfterAbort", 1'b0, 1'b0, 16'h0000);

        applyStimulus(8'h02, 8'h03, 16'h0006, 1'b1);
        waitIdle("finalDrain");
        repeat (3) @(negedge clk);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain: got %0d pending, required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
